ddr3_req_arbiter: RTL and testbench



---
 rtl/ddr3_pkg.sv | 19 +
 rtl/ddr3_addr_decode.sv | 38 +++
 rtl/ddr3_req_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_ddr3_req_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared DDR3 controller definitions: direction encoding, arbiter FSM states
// and the default x16 device geometry.
package ddr3_pkg;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

  localparam int DDR3_BYTE_BITS = 1;
  localparam int DDR3_COL_BITS  = 10;
  localparam int DDR3_BANK_BITS = 3;
  localparam int DDR3_ROW_BITS  = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRSEQ = 2'd1,
    ST_RDSEQ = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ddr3_addr_decode.sv
// Combinational split of a byte address into DDR3 {row, bank, col}; col is
// BL8 aligned and oob_o flags any address bit set above the row field.
module ddr3_addr_decode #(
  parameter int ADDRS     = 32,
  parameter int BYTE_BITS = 1,
  parameter int COL_BITS  = 10,
  parameter int BANK_BITS = 3,
  parameter int ROW_BITS  = 13
) (
  input  logic [ADDRS-1:0]     adr_i,
  output logic [BANK_BITS-1:0] bank_o,
  output logic [ROW_BITS-1:0]  row_o,
  output logic [COL_BITS-1:0]  col_o,
  output logic                 oob_o
);

  localparam int BANK_LSB = BYTE_BITS + COL_BITS;
  localparam int ROW_LSB  = BANK_LSB + BANK_BITS;
  localparam int TOP_LSB  = ROW_LSB + ROW_BITS;

  assign col_o  = adr_i[BYTE_BITS +: COL_BITS] & ~COL_BITS'(7);
  assign bank_o = adr_i[BANK_LSB +: BANK_BITS];
  assign row_o  = adr_i[ROW_LSB +: ROW_BITS];

  generate
    if (ADDRS > TOP_LSB) begin : g_oob
      assign oob_o = |adr_i[ADDRS-1:TOP_LSB];
    end else begin : g_no_oob
      assign oob_o = 1'b0;
    end
    // Byte-lane bits select within one DQ beat and never reach the device.
    if (BYTE_BITS > 0) begin : g_byte
      logic unused_byte;
      assign unused_byte = ^adr_i[BYTE_BITS-1:0];
    end
  endgenerate

endmodule

// File: rtl/ddr3_req_arbiter.sv
// Write/read request arbiter feeding one registered command to the DDR3 FSM.
// Optional out-of-range address rejection: define DDR3_ARB_ADDR_CHECK_EN.
//
//   state    | meaning
//   ST_IDLE  | no sequence open; alternating tie-break between ports
//   ST_WRSEQ | write sequence open; only the write port is granted
//   ST_RDSEQ | read sequence open; only the read port is granted
module ddr3_req_arbiter
  import ddr3_pkg::*;
#(
  parameter int MEM_ID_WIDTH = 4,
  parameter int ADDRS        = 32,
  parameter int BYTE_BITS    = DDR3_BYTE_BITS,
  parameter int COL_BITS     = DDR3_COL_BITS,
  parameter int BANK_BITS    = DDR3_BANK_BITS,
  parameter int ROW_BITS     = DDR3_ROW_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    mem_wrreq_i,
  output logic                    mem_wrack_o,
  output logic                    mem_wrerr_o,
  input  logic                    mem_wrlst_i,
  input  logic [MEM_ID_WIDTH-1:0] mem_wrtid_i,
  input  logic [ADDRS-1:0]        mem_wradr_i,
  input  logic                    mem_rdreq_i,
  output logic                    mem_rdack_o,
  output logic                    mem_rderr_o,
  input  logic                    mem_rdlst_i,
  input  logic [MEM_ID_WIDTH-1:0] mem_rdtid_i,
  input  logic [ADDRS-1:0]        mem_rdadr_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic                    cmd_write_o,
  output logic                    cmd_last_o,
  output logic [MEM_ID_WIDTH-1:0] cmd_tid_o,
  output logic [BANK_BITS-1:0]    cmd_bank_o,
  output logic [ROW_BITS-1:0]     cmd_row_o,
  output logic [COL_BITS-1:0]     cmd_col_o
);

  arb_state_e state_q, state_d;
  logic prefer_rd_q, prefer_rd_d;
  logic grant_wr, grant_rd, space, accept, load;

  logic                    sel_lst;
  logic [MEM_ID_WIDTH-1:0] sel_tid;
  logic [ADDRS-1:0]        sel_adr;
  logic [BANK_BITS-1:0]    dec_bank;
  logic [ROW_BITS-1:0]     dec_row;
  logic [COL_BITS-1:0]     dec_col;
  logic                    dec_oob;

  logic                    cmd_valid_q, cmd_valid_d;
  logic                    cmd_write_q, cmd_write_d;
  logic                    cmd_last_q, cmd_last_d;
  logic [MEM_ID_WIDTH-1:0] cmd_tid_q, cmd_tid_d;
  logic [BANK_BITS-1:0]    cmd_bank_q, cmd_bank_d;
  logic [ROW_BITS-1:0]     cmd_row_q, cmd_row_d;
  logic [COL_BITS-1:0]     cmd_col_q, cmd_col_d;

  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_rdreq_i && (!mem_wrreq_i || prefer_rd_q)) grant_rd = 1'b1;
        else if (mem_wrreq_i)                              grant_wr = 1'b1;
      end
      ST_WRSEQ: grant_wr = mem_wrreq_i;
      ST_RDSEQ: grant_rd = mem_rdreq_i;
      default: ;
    endcase
  end

  // Nothing is accepted while reset is held, so no request is lost to it.
  assign space       = ~cmd_valid_q | cmd_ready_i;
  assign mem_wrack_o = grant_wr & space & ~reset;
  assign mem_rdack_o = grant_rd & space & ~reset;
  assign accept      = mem_wrack_o | mem_rdack_o;

  assign sel_lst = grant_wr ? mem_wrlst_i : mem_rdlst_i;
  assign sel_tid = grant_wr ? mem_wrtid_i : mem_rdtid_i;
  assign sel_adr = grant_wr ? mem_wradr_i : mem_rdadr_i;

  ddr3_addr_decode #(
    .ADDRS     (ADDRS),
    .BYTE_BITS (BYTE_BITS),
    .COL_BITS  (COL_BITS),
    .BANK_BITS (BANK_BITS),
    .ROW_BITS  (ROW_BITS)
  ) u_addr_decode (
    .adr_i  (sel_adr),
    .bank_o (dec_bank),
    .row_o  (dec_row),
    .col_o  (dec_col),
    .oob_o  (dec_oob)
  );

`ifdef DDR3_ARB_ADDR_CHECK_EN
  assign load        = accept & ~dec_oob;
  assign mem_wrerr_o = mem_wrack_o & dec_oob;
  assign mem_rderr_o = mem_rdack_o & dec_oob;
`else
  logic unused_oob;
  assign unused_oob  = dec_oob;
  assign load        = accept;
  assign mem_wrerr_o = 1'b0;
  assign mem_rderr_o = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      prefer_rd_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      prefer_rd_q <= prefer_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prefer_rd_d = prefer_rd_q;
    if (accept) begin
      // A new sequence flips the tie-break toward the other port.
      if (state_q == ST_IDLE) prefer_rd_d = grant_wr;
      if (sel_lst)       state_d = ST_IDLE;
      else if (grant_wr) state_d = ST_WRSEQ;
      else               state_d = ST_RDSEQ;
    end
  end

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_last_d  = cmd_last_q;
    cmd_tid_d   = cmd_tid_q;
    cmd_bank_d  = cmd_bank_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    if (load) begin
      cmd_valid_d = 1'b1;
      cmd_write_d = grant_wr ? CMD_WRITE : CMD_READ;
      cmd_last_d  = sel_lst;
      cmd_tid_d   = sel_tid;
      cmd_bank_d  = dec_bank;
      cmd_row_d   = dec_row;
      cmd_col_d   = dec_col;
    end else if (cmd_ready_i) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_last_q  <= 1'b0;
      cmd_tid_q   <= '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_last_q  <= cmd_last_d;
      cmd_tid_q   <= cmd_tid_d;
      cmd_bank_q  <= cmd_bank_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
    end
  end

  assign cmd_valid_o = cmd_valid_q;
  assign cmd_write_o = cmd_write_q;
  assign cmd_last_o  = cmd_last_q;
  assign cmd_tid_o   = cmd_tid_q;
  assign cmd_bank_o  = cmd_bank_q;
  assign cmd_row_o   = cmd_row_q;
  assign cmd_col_o   = cmd_col_q;

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed bench for ddr3_req_arbiter: arbitration, sequencing, stall,
// reset and address decode, with hand-computed expectations.
module tb_ddr3_req_arbiter;

  logic        clock;
  logic        reset;
  logic        mem_wrreq_i, mem_wrack_o, mem_wrerr_o, mem_wrlst_i;
  logic [3:0]  mem_wrtid_i;
  logic [31:0] mem_wradr_i;
  logic        mem_rdreq_i, mem_rdack_o, mem_rderr_o, mem_rdlst_i;
  logic [3:0]  mem_rdtid_i;
  logic [31:0] mem_rdadr_i;
  logic        cmd_valid_o, cmd_ready_i, cmd_write_o, cmd_last_o;
  logic [3:0]  cmd_tid_o;
  logic [2:0]  cmd_bank_o;
  logic [12:0] cmd_row_o;
  logic [9:0]  cmd_col_o;

  int checks = 0;
  int errors = 0;

  ddr3_req_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .mem_wrreq_i (mem_wrreq_i),
    .mem_wrack_o (mem_wrack_o),
    .mem_wrerr_o (mem_wrerr_o),
    .mem_wrlst_i (mem_wrlst_i),
    .mem_wrtid_i (mem_wrtid_i),
    .mem_wradr_i (mem_wradr_i),
    .mem_rdreq_i (mem_rdreq_i),
    .mem_rdack_o (mem_rdack_o),
    .mem_rderr_o (mem_rderr_o),
    .mem_rdlst_i (mem_rdlst_i),
    .mem_rdtid_i (mem_rdtid_i),
    .mem_rdadr_i (mem_rdadr_i),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .cmd_write_o (cmd_write_o),
    .cmd_last_o  (cmd_last_o),
    .cmd_tid_o   (cmd_tid_o),
    .cmd_bank_o  (cmd_bank_o),
    .cmd_row_o   (cmd_row_o),
    .cmd_col_o   (cmd_col_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_cmd(input string tag, input logic v, input logic w, input logic l,
                         input logic [3:0] t);
    chk({tag, ".valid"}, cmd_valid_o, v);
    chk({tag, ".write"}, cmd_write_o, w);
    chk({tag, ".last"},  cmd_last_o,  l);
    chk({tag, ".tid"},   cmd_tid_o,   t);
  endtask

  initial begin
    reset = 1'b1;
    cmd_ready_i = 1'b1;
    mem_wrreq_i = 0; mem_wrlst_i = 0; mem_wrtid_i = 0; mem_wradr_i = 0;
    mem_rdreq_i = 0; mem_rdlst_i = 0; mem_rdtid_i = 0; mem_rdadr_i = 0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk_cmd("rst", 1'b0, 1'b0, 1'b0, 4'h0);
    chk("rst.bank", cmd_bank_o, 0);
    chk("rst.row", cmd_row_o, 0);
    chk("rst.col", cmd_col_o, 0);
    chk("rst.wrack", mem_wrack_o, 0);
    chk("rst.rdack", mem_rdack_o, 0);
    cyc();

    // Single write: 0x12346 -> col 0x1A3&~7=0x1A0, bank adr[13:11]=4, row adr[26:14]=4
    mem_wrreq_i = 1; mem_wradr_i = 32'h0001_2346; mem_wrlst_i = 1; mem_wrtid_i = 4'd3;
    #1;
    chk("single.wrack", mem_wrack_o, 1);
    chk("single.rdack", mem_rdack_o, 0);
    chk("single.wrerr", mem_wrerr_o, 0);
    cyc();
    mem_wrreq_i = 0;
    chk_cmd("single", 1'b1, 1'b1, 1'b1, 4'd3);
    chk("single.col", cmd_col_o, 10'h1A0);
    chk("single.bank", cmd_bank_o, 3'd4);
    chk("single.row", cmd_row_o, 13'd4);
    cyc();
    chk("single.drain", cmd_valid_o, 0);

    // Tie-break: read first after reset, then alternating
    mem_wrreq_i = 1; mem_wrlst_i = 1; mem_wrtid_i = 4'd5; mem_wradr_i = 32'h0;
    mem_rdreq_i = 1; mem_rdlst_i = 1; mem_rdtid_i = 4'd6; mem_rdadr_i = 32'h100;
    #1;
    chk("tie1.rdack", mem_rdack_o, 1);
    chk("tie1.wrack", mem_wrack_o, 0);
    cyc();
    chk_cmd("tie1", 1'b1, 1'b0, 1'b1, 4'd6);
    chk("tie1.col", cmd_col_o, 10'h080);
    #1;
    chk("tie2.wrack", mem_wrack_o, 1);
    chk("tie2.rdack", mem_rdack_o, 0);
    cyc();
    chk_cmd("tie2", 1'b1, 1'b1, 1'b1, 4'd5);
    #1;
    chk("tie3.rdack", mem_rdack_o, 1);
    chk("tie3.wrack", mem_wrack_o, 0);
    cyc();
    chk_cmd("tie3", 1'b1, 1'b0, 1'b1, 4'd6);

    // Write sequence of 4 with the read port held pending (write preferred now)
    mem_rdtid_i = 4'd7;
    for (int i = 0; i < 4; i++) begin
      mem_wrlst_i = (i == 3);
      mem_wrtid_i = 4'(i);
      #1;
      chk("wrseq.wrack", mem_wrack_o, 1);
      chk("wrseq.rdack", mem_rdack_o, 0);
      cyc();
      chk_cmd("wrseq", 1'b1, 1'b1, (i == 3), 4'(i));
    end
    mem_wrreq_i = 0;
    #1;
    chk("wrseq.rd_after", mem_rdack_o, 1);
    cyc();
    chk_cmd("wrseq.rdcmd", 1'b1, 1'b0, 1'b1, 4'd7);

    // Stall: ready low for 5 cycles with a command loaded
    mem_rdreq_i = 0; cmd_ready_i = 0;
    mem_wrreq_i = 1; mem_wrlst_i = 1; mem_wrtid_i = 4'd9; mem_wradr_i = 32'h0000_0400;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall.wrack", mem_wrack_o, 0);
      chk_cmd("stall", 1'b1, 1'b0, 1'b1, 4'd7);
      chk("stall.col", cmd_col_o, 10'h080);
      cyc();
    end
    cmd_ready_i = 1;
    #1;
    chk("stall.release_wrack", mem_wrack_o, 1);
    cyc();
    mem_wrreq_i = 0;
    chk_cmd("stall.newcmd", 1'b1, 1'b1, 1'b1, 4'd9);
    chk("stall.newcol", cmd_col_o, 10'h200);

    // Reset in the middle of a 4-read sequence, after 2 accepts
    mem_rdreq_i = 1; mem_rdlst_i = 0; mem_rdtid_i = 4'd2; mem_rdadr_i = 32'h100;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rdseq.rdack", mem_rdack_o, 1);
      cyc();
      chk_cmd("rdseq", 1'b1, 1'b0, 1'b0, 4'd2);
    end
    mem_rdreq_i = 0;
    mem_wrreq_i = 1; mem_wrlst_i = 1; mem_wrtid_i = 4'hA; mem_wradr_i = 32'h0;
    reset = 1;
    #1;
    chk("midrst.wrack_in_reset", mem_wrack_o, 0);
    cyc();
    chk_cmd("midrst", 1'b0, 1'b0, 1'b0, 4'd0);
    reset = 0;
    #1;
    chk("midrst.wrack_after", mem_wrack_o, 1);
    cyc();
    mem_wrreq_i = 0;
    chk_cmd("midrst.wrcmd", 1'b1, 1'b1, 1'b1, 4'hA);

    // Address with bits above the row field set
    mem_rdreq_i = 1; mem_rdlst_i = 1; mem_rdtid_i = 4'd4; mem_rdadr_i = 32'h8000_0000;
    #1;
    chk("oob.rdack", mem_rdack_o, 1);
`ifdef DDR3_ARB_ADDR_CHECK_EN
    chk("oob.rderr", mem_rderr_o, 1);
`else
    chk("oob.rderr", mem_rderr_o, 0);
`endif
    cyc();
    mem_rdreq_i = 0;
`ifdef DDR3_ARB_ADDR_CHECK_EN
    chk("oob.no_cmd", cmd_valid_o, 0);
`else
    chk_cmd("oob.cmd", 1'b1, 1'b0, 1'b1, 4'd4);
    chk("oob.row", cmd_row_o, 0);
    chk("oob.bank", cmd_bank_o, 0);
    chk("oob.col", cmd_col_o, 0);
`endif
    mem_wrreq_i = 1; mem_wrlst_i = 1; mem_wrtid_i = 4'd1; mem_wradr_i = 32'h0;
    #1;
    chk("oob.idle_wrack", mem_wrack_o, 1);
    cyc();
    mem_wrreq_i = 0;
    chk_cmd("oob.wrcmd", 1'b1, 1'b1, 1'b1, 4'd1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
